// File: rtl/simon_sound_if.sv
// simon_sound_if: signal bundle between the Simon controller and the tone
// generator.
//   LAMP[1:0]  lamp index from the controller
//   LAMP_ENA   lamp lit
//   LOSE       lose level (a rising edge starts the buzz)
//   HS         high-score level (a rising edge starts the jingle)
//   SPKR       square-wave speaker drive
//   BUSY       buzz or jingle in progress
// The master modport is the controller side; the slave modport is the tone generator.
interface simon_sound_if;
  logic [1:0] LAMP;
  logic       LAMP_ENA;
  logic       LOSE;
  logic       HS;
  logic       SPKR;
  logic       BUSY;

  modport master (output LAMP, output LAMP_ENA, output LOSE, output HS,
                  input SPKR, input BUSY);
  modport slave  (input LAMP, input LAMP_ENA, input LOSE, input HS,
                  output SPKR, output BUSY);
endinterface

// File: rtl/simon_sound.sv
// simon_sound: tone generator for the Simon game.
// It mirrors the lit lamp with a per-colour square wave, plays a low buzz on a
// LOSE rise and plays a four-note jingle on an HS rise.
// Ports:
//   CLK  clock; all state changes on its rising edge
//   RST  asynchronous active-high reset
//   bus  simon_sound_if.slave (LAMP, LAMP_ENA, LOSE, HS in; SPKR, BUSY out, registered)
// Build option: define SIMON_SOUND_JINGLE_EN to build the high-score jingle.
// Without it, HS is ignored and only the lose buzz drives BUSY.
module simon_sound #(
  parameter int DIV_W     = 16,
  parameter int LEN_W     = 24,
  parameter int HALF_P0   = 4000,
  parameter int HALF_P1   = 3200,
  parameter int HALF_P2   = 2700,
  parameter int HALF_P3   = 2400,
  parameter int HALF_LOSE = 8000,
  parameter int LOSE_LEN  = 4000000,
  parameter int NOTE_LEN  = 1000000
) (
  input  logic          CLK,
  input  logic          RST,
  simon_sound_if.slave  bus
);

  localparam logic [DIV_W-1:0] H0          = DIV_W'(HALF_P0);
  localparam logic [DIV_W-1:0] H1          = DIV_W'(HALF_P1);
  localparam logic [DIV_W-1:0] H2          = DIV_W'(HALF_P2);
  localparam logic [DIV_W-1:0] H3          = DIV_W'(HALF_P3);
  localparam logic [DIV_W-1:0] HL          = DIV_W'(HALF_LOSE);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] LOSE_RELOAD = LEN_W'(LOSE_LEN - 1);
`ifdef SIMON_SOUND_JINGLE_EN
  localparam logic [LEN_W-1:0] NOTE_RELOAD = LEN_W'(NOTE_LEN - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOSE   = 2'd1
`ifdef SIMON_SOUND_JINGLE_EN
    ,S_JINGLE = 2'd2
`endif
  } state_t;

  // Lamp index (or jingle note) to tone half-period.
  function automatic logic [DIV_W-1:0] colour_half(input logic [1:0] idx);
    case (idx)
      2'd0:    colour_half = H0;
      2'd1:    colour_half = H1;
      2'd2:    colour_half = H2;
      2'd3:    colour_half = H3;
      default: colour_half = H0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [LEN_W-1:0] dur_q, dur_d;
  logic             lose_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] half_q, half_d;   // half-period currently playing, 0 = silent
  logic             spkr_q, spkr_d;
  logic             busy_q, busy_d;
  logic [DIV_W-1:0] sel_s;            // half-period requested this cycle, 0 = silent
  logic             lose_rise_s;
`ifdef SIMON_SOUND_JINGLE_EN
  logic             hs_q;
  logic [1:0]       note_q, note_d;
  logic             hs_rise_s;
  assign hs_rise_s = bus.HS & ~hs_q;
`endif

  assign lose_rise_s = bus.LOSE & ~lose_q;

  // Sequencer: next state, duration and note, plus the requested tone.
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    sel_s   = '0;
`ifdef SIMON_SOUND_JINGLE_EN
    note_d  = note_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.LAMP_ENA) begin
          sel_s = colour_half(bus.LAMP);
        end else begin
          sel_s = '0;
        end
        // LOSE has priority over HS when both rise together.
        if (lose_rise_s) begin
          state_d = S_LOSE;
          dur_d   = LOSE_RELOAD;
`ifdef SIMON_SOUND_JINGLE_EN
        end else if (hs_rise_s) begin
          state_d = S_JINGLE;
          dur_d   = NOTE_RELOAD;
          note_d  = 2'd0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOSE: begin
        sel_s = HL;
        if (lose_rise_s) begin
          dur_d = LOSE_RELOAD;
        end else if (dur_q == '0) begin
          state_d = S_IDLE;
        end else begin
          dur_d = dur_q - LEN_ONE;
        end
      end
`ifdef SIMON_SOUND_JINGLE_EN
      S_JINGLE: begin
        sel_s = colour_half(note_q);
        if (lose_rise_s) begin
          state_d = S_LOSE;
          dur_d   = LOSE_RELOAD;
        end else if (dur_q == '0) begin
          if (note_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            note_d = note_q + 2'd1;
            dur_d  = NOTE_RELOAD;
          end
        end else begin
          dur_d = dur_q - LEN_ONE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tone engine: reload on any tone change, toggle at the end of each half-period.
  always_comb begin
    half_d = sel_s;
    div_d  = div_q;
    spkr_d = spkr_q;
    busy_d = (state_q != S_IDLE);
    if (sel_s == '0) begin
      div_d  = '0;
      spkr_d = 1'b0;
    end else if (sel_s != half_q) begin
      // Keep the current level across a pitch change, but start low from silence.
      div_d  = sel_s - DIV_ONE;
      spkr_d = (half_q == '0) ? 1'b0 : spkr_q;
    end else if (div_q == '0) begin
      div_d  = sel_s - DIV_ONE;
      spkr_d = ~spkr_q;
    end else begin
      div_d  = div_q - DIV_ONE;
      spkr_d = spkr_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      dur_q   <= '0;
      lose_q  <= 1'b0;
      div_q   <= '0;
      half_q  <= '0;
      spkr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      lose_q  <= bus.LOSE;
      div_q   <= div_d;
      half_q  <= half_d;
      spkr_q  <= spkr_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SIMON_SOUND_JINGLE_EN
  // Jingle-only state: HS edge history and note index.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hs_q   <= 1'b0;
      note_q <= 2'd0;
    end else begin
      hs_q   <= bus.HS;
      note_q <= note_d;
    end
  end
`endif

  assign bus.SPKR = spkr_q;
  assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_simon_sound.sv
// tb_simon_sound: scoreboard bench for simon_sound.
// Stimulus pushes the expected SPKR and BUSY transitions (value and edge number)
// into per-signal queues; a monitor on the falling clock edge pops and compares
// whenever an output changes. Edge numbers count rising clock edges (cyc).
module tb_simon_sound;

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  logic CLK;
  logic RST;
  int   cyc;
  int   n_cmp;
  int   n_err;
  ev_t  sq[$];
  ev_t  bq[$];
  logic ps;
  logic pb;

  simon_sound_if bus ();

  simon_sound #(
    .DIV_W(16), .LEN_W(24),
    .HALF_P0(4), .HALF_P1(5), .HALF_P2(6), .HALF_P3(7),
    .HALF_LOSE(10), .LOSE_LEN(100), .NOTE_LEN(40)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0b, expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge CLK);
  endtask

  task automatic push_b(input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    bq.push_back(e);
  endtask

  // Expected toggles of a tone of half-period 'half' selected from edge s to edge last.
  task automatic seg(input int s, input int half, input int last,
                     input logic lvl_i, output logic lvl_o);
    ev_t  e;
    logic l;
    l = lvl_i;
    for (int t = s + half; t <= last; t += half) begin
      l = ~l;
      e.cyc = t;
      e.val = l;
      sq.push_back(e);
    end
    lvl_o = l;
  endtask

  // Expected fall when the tone goes silent at edge e.
  task automatic silence(input int e, input logic lvl);
    ev_t x;
    if (lvl) begin
      x.cyc = e;
      x.val = 1'b0;
      sq.push_back(x);
    end
  endtask

  // Monitor: compare every output transition against the scoreboard.
  always @(negedge CLK) begin
    ev_t e;
    if (RST) begin
      ps = bus.SPKR;
      pb = bus.BUSY;
    end else begin
      if (bus.SPKR !== ps) begin
        n_cmp = n_cmp + 1;
        if (sq.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL spkr_extra: SPKR went to %0b at cycle %0d, no change expected", bus.SPKR, cyc);
        end else begin
          e = sq.pop_front();
          if (e.cyc != cyc || e.val !== bus.SPKR) begin
            n_err = n_err + 1;
            $display("FAIL spkr_edge: SPKR went to %0b at cycle %0d, expected %0b at cycle %0d",
                     bus.SPKR, cyc, e.val, e.cyc);
          end
        end
        ps = bus.SPKR;
      end
      if (bus.BUSY !== pb) begin
        n_cmp = n_cmp + 1;
        if (bq.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL busy_extra: BUSY went to %0b at cycle %0d, no change expected", bus.BUSY, cyc);
        end else begin
          e = bq.pop_front();
          if (e.cyc != cyc || e.val !== bus.BUSY) begin
            n_err = n_err + 1;
            $display("FAIL busy_edge: BUSY went to %0b at cycle %0d, expected %0b at cycle %0d",
                     bus.BUSY, cyc, e.val, e.cyc);
          end
        end
        pb = bus.BUSY;
      end
    end
  end

  initial begin
    int   k;
    int   l_e;
    int   h;
    int   a;
    logic lvl;
    n_cmp = 0;
    n_err = 0;
    ps    = 1'b0;
    pb    = 1'b0;
    RST   = 1'b1;
    bus.LAMP     = 2'd0;
    bus.LAMP_ENA = 1'b0;
    bus.LOSE     = 1'b0;
    bus.HS       = 1'b0;

    // Reset held with random inputs: outputs stay low.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("rst_spkr", bus.SPKR, 1'b0);
      chk("rst_busy", bus.BUSY, 1'b0);
      bus.LAMP     = 2'($urandom_range(0, 3));
      bus.LAMP_ENA = 1'($urandom_range(0, 1));
      bus.LOSE     = 1'($urandom_range(0, 1));
      bus.HS       = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    RST          = 1'b0;
    bus.LAMP     = 2'd0;
    bus.LAMP_ENA = 1'b0;
    bus.LOSE     = 1'b0;
    bus.HS       = 1'b0;
    wait_until(cyc + 6);
    chk("idle_spkr", bus.SPKR, 1'b0);
    chk("idle_busy", bus.BUSY, 1'b0);

    // Lamp 2 for 60 cycles: half-period 6, then silence.
    k = cyc + 1;
    bus.LAMP     = 2'd2;
    bus.LAMP_ENA = 1'b1;
    seg(k, 6, k + 59, 1'b0, lvl);
    silence(k + 60, lvl);
    wait_until(k + 59);
    bus.LAMP_ENA = 1'b0;
    wait_until(k + 60);
    chk("lamp_off_spkr", bus.SPKR, 1'b0);
    chk("lamp_off_busy", bus.BUSY, 1'b0);
    wait_until(cyc + 4);

    // Lose buzz over a running lamp-0 tone; lamp tone resumes afterwards.
    k   = cyc + 1;
    l_e = k + 14;
    bus.LAMP     = 2'd0;
    bus.LAMP_ENA = 1'b1;
    seg(k, 4, l_e, 1'b0, lvl);
    seg(l_e + 1, 10, l_e + 100, lvl, lvl);
    seg(l_e + 101, 4, l_e + 117, lvl, lvl);
    silence(l_e + 118, lvl);
    push_b(l_e + 1, 1'b1);
    push_b(l_e + 101, 1'b0);
    wait_until(l_e - 1);
    bus.LOSE = 1'b1;
    wait_until(l_e);
    bus.LOSE = 1'b0;
    bus.LAMP = 2'd3;
    wait_until(l_e + 50);
    chk("lose_busy_mid", bus.BUSY, 1'b1);
    bus.LAMP = 2'd0;
    wait_until(l_e + 117);
    bus.LAMP_ENA = 1'b0;
    wait_until(l_e + 125);
    chk("lose_end_busy", bus.BUSY, 1'b0);

    // HS pulse: jingle when built, otherwise nothing.
    h = cyc + 1;
    bus.HS = 1'b1;
`ifdef SIMON_SOUND_JINGLE_EN
    push_b(h + 1, 1'b1);
    push_b(h + 161, 1'b0);
    seg(h + 1, 4, h + 40, 1'b0, lvl);
    seg(h + 41, 5, h + 80, lvl, lvl);
    seg(h + 81, 6, h + 120, lvl, lvl);
    seg(h + 121, 7, h + 160, lvl, lvl);
    silence(h + 161, lvl);
`endif
    wait_until(h);
    bus.HS = 1'b0;
    wait_until(h + 80);
`ifdef SIMON_SOUND_JINGLE_EN
    chk("hs_busy_mid", bus.BUSY, 1'b1);
`else
    chk("hs_busy_mid", bus.BUSY, 1'b0);
    chk("hs_spkr_mid", bus.SPKR, 1'b0);
`endif
    wait_until(h + 170);
    chk("hs_end_busy", bus.BUSY, 1'b0);
    chk("hs_end_spkr", bus.SPKR, 1'b0);

    // LOSE rise during jingle note 2 aborts to a full buzz.
    h = cyc + 1;
    a = h + 90;
    bus.HS = 1'b1;
    lvl = 1'b0;
`ifdef SIMON_SOUND_JINGLE_EN
    push_b(h + 1, 1'b1);
    seg(h + 1, 4, h + 40, lvl, lvl);
    seg(h + 41, 5, h + 80, lvl, lvl);
    seg(h + 81, 6, a, lvl, lvl);
`else
    push_b(a + 1, 1'b1);
`endif
    push_b(a + 101, 1'b0);
    seg(a + 1, 10, a + 100, lvl, lvl);
    silence(a + 101, lvl);
    wait_until(h);
    bus.HS = 1'b0;
    wait_until(a - 1);
    bus.LOSE = 1'b1;
    wait_until(a);
    bus.LOSE = 1'b0;
    wait_until(a + 110);

    // LOSE and HS rising together: buzz only.
    k = cyc + 1;
    bus.LOSE = 1'b1;
    bus.HS   = 1'b1;
    push_b(k + 1, 1'b1);
    push_b(k + 101, 1'b0);
    seg(k + 1, 10, k + 100, 1'b0, lvl);
    silence(k + 101, lvl);
    wait_until(k);
    bus.LOSE = 1'b0;
    bus.HS   = 1'b0;
    wait_until(k + 110);
    chk("both_end_busy", bus.BUSY, 1'b0);

    // Reset asserted mid-buzz clears outputs without a clock edge.
    k = cyc + 1;
    bus.LOSE = 1'b1;
    push_b(k + 1, 1'b1);
    seg(k + 1, 10, k + 31, 1'b0, lvl);
    wait_until(k);
    bus.LOSE = 1'b0;
    wait_until(k + 32);
    chk("pre_rst_spkr", bus.SPKR, 1'b1);
    chk("pre_rst_busy", bus.BUSY, 1'b1);
    chk_int("pre_rst_sq_empty", sq.size(), 0);
    chk_int("pre_rst_bq_empty", bq.size(), 0);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_spkr", bus.SPKR, 1'b0);
    chk("async_rst_busy", bus.BUSY, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    wait_until(cyc + 10);
    chk("post_rst_spkr", bus.SPKR, 1'b0);
    chk("post_rst_busy", bus.BUSY, 1'b0);

    chk_int("end_sq_empty", sq.size(), 0);
    chk_int("end_bq_empty", bq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
